mem_stage_sram_ctrl: RTL and testbench

MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

---
 rtl/mem_stage_sram_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: one 32-bit load/store as two 16-bit async-SRAM accesses, 6 cycles per request.
// ready drops for 5 cycles per request so the pipeline freezes; writes use S1-S2, reads sample the bus at the end of S2 and S4.
module mem_stage_sram_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] ALU_res_in,
    input  logic [31:0] val_Rm_in,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5} state_t;

    state_t      r_state;
    logic        r_is_wr;
    logic [16:0] r_word;
    logic [31:0] r_data;
    logic [31:0] r_read_data;
    logic [17:0] r_sram_addr;
    logic [15:0] r_dq_out;
    logic        r_dq_oe;
    logic        r_we_n;
    logic        r_oe_n;

    logic        w_req;
    logic [16:0] w_word_in;
    logic        w_unused_addr_bits;

    assign w_req = mem_read_in | mem_write_in;

    // Data memory starts at byte 1024; its low 10 bits are zero, so the subtraction only touches bits [18:10].
    assign w_word_in          = ALU_res_in[18:2] - 17'd256;
    assign w_unused_addr_bits = ^{ALU_res_in[31:19], ALU_res_in[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_wr     <= 1'b0;
            r_word      <= '0;
            r_data      <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state     <= S1;
                        r_is_wr     <= mem_write_in;
                        r_word      <= w_word_in;
                        r_data      <= val_Rm_in;
                        r_sram_addr <= {w_word_in, 1'b0};
                        if (mem_write_in) begin
                            r_dq_out <= val_Rm_in[15:0];
                            r_dq_oe  <= 1'b1;
                            r_we_n   <= 1'b0;
                        end else begin
                            r_oe_n   <= 1'b0;
                        end
                    end
                end
                S1: begin
                    r_state <= S2;
                    if (r_is_wr) begin
                        r_sram_addr <= {r_word, 1'b1};
                        r_dq_out    <= r_data[31:16];
                    end
                end
                S2: begin
                    r_state     <= S3;
                    r_sram_addr <= {r_word, 1'b1};
                    if (r_is_wr) begin
                        r_we_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                    end else begin
                        r_read_data[15:0] <= SRAM_DQ_in;
                    end
                end
                S3: begin
                    r_state <= S4;
                end
                S4: begin
                    r_state <= S5;
                    r_oe_n  <= 1'b1;
                    if (!r_is_wr) begin
                        r_read_data[31:16] <= SRAM_DQ_in;
                    end
                end
                S5: begin
                    // Any request seen here is deliberately ignored and picked up in the next IDLE.
                    r_state     <= IDLE;
                    r_sram_addr <= '0;
                    r_dq_out    <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Reset kills the write strobe in the cycle it is raised, so an abandoned store never lands its second half.
    assign SRAM_WE_N   = r_we_n | rst;
    assign SRAM_DQ_oe  = r_dq_oe & ~rst;
    assign SRAM_OE_N   = r_oe_n;
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_DQ_out = r_dq_out;
    assign SRAM_CE_N   = 1'b0;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;
    assign read_data   = r_read_data;
    assign ready       = (r_state == S5) || ((r_state == IDLE) && !w_req);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: behavioural SRAM plus write/completion scoreboards fed by directed requests.
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [31:0] ALU_res_in = '0;
    logic [31:0] val_Rm_in = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    mem_stage_sram_ctrl dut (
        .clk(clk), .rst(rst), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .ALU_res_in(ALU_res_in), .val_Rm_in(val_Rm_in), .read_data(read_data), .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_DQ_in(SRAM_DQ_in), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 clk = ~clk;

    // SRAM model: a write commits on the clock edge while the strobe is low.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) mem[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
    end
    assign SRAM_DQ_in = SRAM_OE_N ? 16'h0000 : mem[SRAM_ADDR[7:0]];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [17:0] a; logic [15:0] d; } wr_t;
    typedef struct packed { logic is_rd; logic [31:0] rd; } done_t;
    wr_t   wr_q[$];
    done_t done_q[$];

    // Monitor: every write strobe and every request completion is matched against the queues.
    int    stall = 0;
    wr_t   mw;
    done_t md;
    always @(negedge clk) begin
        if (!SRAM_WE_N) begin
            if (wr_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wr_unexpected: addr %0h data %0h, no write expected", SRAM_ADDR, SRAM_DQ_out);
            end else begin
                mw = wr_q.pop_front();
                chk("wr_addr", SRAM_ADDR, mw.a);
                chk("wr_data", SRAM_DQ_out, mw.d);
                chk("wr_dq_oe", SRAM_DQ_oe, 1);
            end
        end
        if (!SRAM_OE_N) chk("bus_contention_dq_oe", SRAM_DQ_oe, 0);
        if (rst) begin
            stall = 0;
        end else if (mem_read_in || mem_write_in) begin
            if (!ready) begin
                stall++;
            end else if (done_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_unexpected: completion seen, none expected");
                stall = 0;
            end else begin
                md = done_q.pop_front();
                chk("stall_cycles", stall, 5);
                if (md.is_rd) chk("load_read_data", read_data, md.rd);
                stall = 0;
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit scramble, output int cycles);
        mem_read_in  = rd;
        mem_write_in = wr;
        ALU_res_in   = addr;
        val_Rm_in    = data;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cycles++;
            if (ready) break;
            if (scramble && i == 1) begin
                ALU_res_in = 32'h0000_07FC;
                val_Rm_in  = 32'h0;
            end
        end
        chk("req_done_ready", ready, 1);
    endtask

    task automatic clear_req();
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        ALU_res_in   = '0;
        val_Rm_in    = '0;
    endtask

    int c1, c2;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_read_data", read_data, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_we_n", SRAM_WE_N, 1);
        chk("rst_oe_n", SRAM_OE_N, 1);
        chk("rst_dq_oe", SRAM_DQ_oe, 0);
        chk("rst_dq_out", SRAM_DQ_out, 0);
        chk("rst_ready", ready, 1);
        chk("tie_ce_ub_lb", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", ready, 1);
            chk("idle_we_n", SRAM_WE_N, 1);
            chk("idle_dq_oe", SRAM_DQ_oe, 0);
        end

        // Store 0xDEADBEEF to 1028 -> halfwords 2 and 3.
        wr_q.push_back('{a: 18'd2, d: 16'hBEEF});
        wr_q.push_back('{a: 18'd3, d: 16'hDEAD});
        done_q.push_back('{is_rd: 1'b0, rd: 32'h0});
        @(posedge clk); #1;
        do_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, c1);
        chk("store_cycles", c1, 6);
        @(posedge clk); #1 clear_req();

        // Load from 1028 while the EX inputs wander after the request is latched.
        done_q.push_back('{is_rd: 1'b1, rd: 32'hDEADBEEF});
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, c1);
        chk("load_cycles", c1, 6);
        @(posedge clk); #1 clear_req();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("load_data_held", read_data, 32'hDEADBEEF);
        end

        // Read and write together at 1024: the write wins.
        wr_q.push_back('{a: 18'd0, d: 16'h5678});
        wr_q.push_back('{a: 18'd1, d: 16'h1234});
        done_q.push_back('{is_rd: 1'b0, rd: 32'h0});
        @(posedge clk); #1;
        do_req(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, c1);
        @(posedge clk); #1 clear_req();
        @(negedge clk);
        chk("rw_read_data_unchanged", read_data, 32'hDEADBEEF);

        // Reset raised during S2 of a store to 1040: only the low half may be written.
        wr_q.push_back('{a: 18'd8, d: 16'hF00D});
        @(posedge clk); #1;
        mem_write_in = 1'b1;
        ALU_res_in   = 32'd1040;
        val_Rm_in    = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_req();
        @(negedge clk);
        chk("midrst_we_n", SRAM_WE_N, 1);
        chk("midrst_dq_oe", SRAM_DQ_oe, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", ready, 1);
        chk("postrst_we_n", SRAM_WE_N, 1);
        chk("postrst_dq_oe", SRAM_DQ_oe, 0);
        chk("postrst_addr", SRAM_ADDR, 0);
        chk("postrst_read_data", read_data, 0);

        // Back-to-back store then load at 1032, requests held by a frozen pipeline.
        wr_q.push_back('{a: 18'd4, d: 16'h5A5A});
        wr_q.push_back('{a: 18'd5, d: 16'hA5A5});
        done_q.push_back('{is_rd: 1'b0, rd: 32'h0});
        done_q.push_back('{is_rd: 1'b1, rd: 32'hA5A55A5A});
        @(posedge clk); #1;
        do_req(1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b0, c1);
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, c2);
        chk("b2b_total_cycles", c1 + c2, 12);
        @(posedge clk); #1 clear_req();

        repeat (3) @(negedge clk);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
